// File: rtl/irrig_pkg.sv
// Shared types for the irrigation scheduler: state encodings (also used by the
// matrix display), source identifiers and the valve output bundle.
package irrig_pkg;

    localparam int unsigned LEVEL_W = 3;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_RUN_ASP = 3'd1;
    localparam logic [STATE_W-1:0] ST_RUN_GOT = 3'd2;
    localparam logic [STATE_W-1:0] ST_CLEAN   = 3'd3;
    localparam logic [STATE_W-1:0] ST_FAULT   = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = ST_IDLE,
        RUN_ASP = ST_RUN_ASP,
        RUN_GOT = ST_RUN_GOT,
        CLEAN   = ST_CLEAN,
        FAULT   = ST_FAULT
    } irrig_state_t;

    typedef enum logic {
        SRC_ASP = 1'b0,
        SRC_GOT = 1'b1
    } irrig_src_t;

    typedef struct packed {
        logic grant_asp;
        logic grant_got;
        logic outlet_open;
        logic adb_valve;
        logic cleaning;
    } irrig_valves_t;

    // Valve pattern for a given state; the injector only follows dose in RUN_ASP.
    function automatic irrig_valves_t valves_for(irrig_state_t st, logic dose);
        irrig_valves_t v;
        v = '0;
        case (st)
            RUN_ASP: begin
                v.grant_asp   = 1'b1;
                v.outlet_open = 1'b1;
                v.adb_valve   = dose;
            end
            RUN_GOT: begin
                v.grant_got   = 1'b1;
                v.outlet_open = 1'b1;
            end
            CLEAN: begin
                v.cleaning    = 1'b1;
                v.outlet_open = 1'b1;
            end
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/irrig_tick_timer.sv
// Loadable down-counter advanced by the tick enable; done_c flags a zero count.
module irrig_tick_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/irrigation_scheduler.sv
// Tank outlet scheduler: round-robin sprinkler/drip runs, level fault, post-dose flush.
// Optional IRRIG_RUN_COUNT_EN adds a saturating count of normally completed runs.
module irrigation_scheduler
    import irrig_pkg::*;
#(
    parameter int unsigned ASP_TICKS   = 8,
    parameter int unsigned GOT_TICKS   = 12,
    parameter int unsigned CLEAN_TICKS = 4,
    parameter int unsigned MIN_LEVEL   = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               req_asp,
    input  logic               req_got,
    input  logic               req_adb,
    input  logic [LEVEL_W-1:0] level,
    output logic               grant_asp,
    output logic               grant_got,
    output logic               outlet_open,
    output logic               adb_valve,
    output logic               cleaning,
    output logic               err_low,
    output logic [STATE_W-1:0] state_o
`ifdef IRRIG_RUN_COUNT_EN
    ,
    output logic [7:0]         run_count
`endif
);

    irrig_state_t  state, next_state;
    irrig_src_t    last_served, next_last;
    logic          dose_pend, next_dose;
    logic          next_err;
    irrig_valves_t valves, next_valves;

    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             done_c;
    logic             run_done;
    logic             level_low;
    logic             own_req;

    assign level_low = (level < LEVEL_W'(MIN_LEVEL));

    irrig_tick_timer #(.W(CNT_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .done_c   (done_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_served <= SRC_GOT;
            dose_pend   <= 1'b0;
            err_low     <= 1'b0;
            valves      <= '0;
            state_o     <= ST_IDLE;
        end else begin
            state       <= next_state;
            last_served <= next_last;
            dose_pend   <= next_dose;
            err_low     <= next_err;
            valves      <= next_valves;
            state_o     <= next_state;
        end
    end

    // Level faults take precedence over run expiry and request drop.
    always_comb begin
        next_state = state;
        next_last  = last_served;
        next_dose  = dose_pend;
        next_err   = err_low;
        load       = 1'b0;
        load_val   = '0;
        run_done   = 1'b0;
        own_req    = (state == RUN_ASP) ? req_asp : req_got;

        case (state)
            IDLE: begin
                if ((req_asp || req_got) && level_low) begin
                    next_state = FAULT;
                    next_err   = 1'b1;
                end else if (req_asp && (!req_got || (last_served == SRC_GOT))) begin
                    next_state = RUN_ASP;
                    next_last  = SRC_ASP;
                    next_dose  = req_adb;
                    load       = 1'b1;
                    load_val   = CNT_W'(ASP_TICKS - 1);
                end else if (req_got) begin
                    next_state = RUN_GOT;
                    next_last  = SRC_GOT;
                    load       = 1'b1;
                    load_val   = CNT_W'(GOT_TICKS - 1);
                end
            end
            RUN_ASP, RUN_GOT: begin
                if (level_low) begin
                    next_state = FAULT;
                    next_err   = 1'b1;
                end else if (!own_req || (tick && done_c)) begin
                    run_done = tick && done_c;
                    if (dose_pend) begin
                        next_state = CLEAN;
                        load       = 1'b1;
                        load_val   = CNT_W'(CLEAN_TICKS - 1);
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            CLEAN: begin
                if (level_low) begin
                    next_state = FAULT;
                    next_err   = 1'b1;
                end else if (tick && done_c) begin
                    next_state = IDLE;
                    next_dose  = 1'b0;
                end
            end
            FAULT: begin
                if (!level_low) begin
                    next_err = 1'b0;
                    if (dose_pend) begin
                        next_state = CLEAN;
                        load       = 1'b1;
                        load_val   = CNT_W'(CLEAN_TICKS - 1);
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase

        next_valves = valves_for(next_state, next_dose);
    end

    assign grant_asp   = valves.grant_asp;
    assign grant_got   = valves.grant_got;
    assign outlet_open = valves.outlet_open;
    assign adb_valve   = valves.adb_valve;
    assign cleaning    = valves.cleaning;

`ifdef IRRIG_RUN_COUNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_count <= 8'd0;
        end else if (run_done && (run_count != 8'hFF)) begin
            run_count <= run_count + 8'd1;
        end
    end
`else
    logic unused_run_done;
    assign unused_run_done = run_done;
`endif

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler: a tick-budget reference model pushes
// expected outputs per clock; a monitor pops and compares after each rising edge.
module tb_irrigation_scheduler;

    logic       clock;
    logic       reset;
    logic       tick;
    logic       req_asp, req_got, req_adb;
    logic [2:0] level;
    logic       grant_asp, grant_got, outlet_open, adb_valve, cleaning, err_low;
    logic [2:0] state_o;
`ifdef IRRIG_RUN_COUNT_EN
    logic [7:0] run_count;
`endif

    irrigation_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .req_asp     (req_asp),
        .req_got     (req_got),
        .req_adb     (req_adb),
        .level       (level),
        .grant_asp   (grant_asp),
        .grant_got   (grant_got),
        .outlet_open (outlet_open),
        .adb_valve   (adb_valve),
        .cleaning    (cleaning),
        .err_low     (err_low),
        .state_o     (state_o)
`ifdef IRRIG_RUN_COUNT_EN
        ,
        .run_count   (run_count)
`endif
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       ga;
        logic       gg;
        logic       outlet;
        logic       adb;
        logic       cln;
        logic       err;
        logic [2:0] st;
`ifdef IRRIG_RUN_COUNT_EN
        logic [7:0] rc;
`endif
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: mode 0 idle, 1 sprinkler, 2 drip, 3 flush, 4 fault;
    // m_left is the number of ticks still owed to the current run or flush.
    int m_mode, m_left, m_rc;
    bit m_last_asp, m_dose, m_err;

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_rc = 0;
        m_last_asp = 1'b0; m_dose = 1'b0; m_err = 1'b0;
    endtask

    task automatic end_run();
        if (m_dose) begin m_mode = 3; m_left = 4; end
        else m_mode = 0;
    endtask

    task automatic model_step(logic ra, logic rg, logic rad, logic [2:0] lv, logic tk);
        bit low;
        bit own;
        bit fin;
        low = (lv < 3'd2);
        fin = 1'b0;
        case (m_mode)
            0: if (ra || rg) begin
                if (low) begin m_mode = 4; m_err = 1'b1; end
                else if (ra && (!rg || !m_last_asp)) begin
                    m_mode = 1; m_left = 8; m_last_asp = 1'b1; m_dose = rad;
                end else begin
                    m_mode = 2; m_left = 12; m_last_asp = 1'b0;
                end
            end
            1, 2: begin
                own = (m_mode == 1) ? ra : rg;
                if (low) begin m_mode = 4; m_err = 1'b1; end
                else begin
                    if (tk) begin
                        m_left--;
                        if (m_left == 0) begin
                            fin = 1'b1;
                            if (m_rc < 255) m_rc++;
                        end
                    end
                    if (fin || !own) end_run();
                end
            end
            3: begin
                if (low) begin m_mode = 4; m_err = 1'b1; end
                else if (tk) begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 0; m_dose = 1'b0; end
                end
            end
            4: if (!low) begin
                m_err = 1'b0;
                if (m_dose) begin m_mode = 3; m_left = 4; end
                else m_mode = 0;
            end
            default: m_mode = 0;
        endcase
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        e.ga     = (m_mode == 1);
        e.gg     = (m_mode == 2);
        e.outlet = (m_mode >= 1) && (m_mode <= 3);
        e.adb    = (m_mode == 1) && m_dose;
        e.cln    = (m_mode == 3);
        e.err    = m_err;
        e.st     = 3'(m_mode);
`ifdef IRRIG_RUN_COUNT_EN
        e.rc     = 8'(m_rc);
`endif
        return e;
    endfunction

    task automatic step(logic rst, logic ra, logic rg, logic rad, logic [2:0] lv, logic tk);
        @(negedge clock);
        reset = rst; req_asp = ra; req_got = rg; req_adb = rad; level = lv; tick = tk;
        cyc++;
        if (!rst) model_reset();
        else model_step(ra, rg, rad, lv, tk);
        exp_q.push_back(expect_now());
        if (!rst) begin
            #1;
            checks++;
            if ({grant_asp, grant_got, outlet_open, adb_valve, cleaning} != 5'b0) begin
                errors++;
                $display("FAIL async_reset_valves: got %b required 00000",
                         {grant_asp, grant_got, outlet_open, adb_valve, cleaning});
            end
        end
    endtask

    task automatic hold(int n, logic ra, logic rg, logic rad, logic [2:0] lv, int div);
        for (int i = 0; i < n; i++) step(1'b1, ra, rg, rad, lv, (cyc % div) == 0);
    endtask

    // Monitor: one expected entry per rising edge.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clock);
            #1;
            a = {grant_asp, grant_got, outlet_open, adb_valve, cleaning, err_low, state_o
`ifdef IRRIG_RUN_COUNT_EN
                 , run_count
`endif
                };
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: got output %h with no expected entry at cycle %0d", a, cyc);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got %h required %h (ga gg out adb cln err st)",
                             cyc, a, e);
                end
            end
            checks++;
            if (grant_asp && grant_got) begin
                errors++;
                $display("FAIL grant_exclusive: got both grants 1 required at most one");
            end
            checks++;
            if (adb_valve && !grant_asp) begin
                errors++;
                $display("FAIL adb_needs_asp: got adb_valve=1 grant_asp=0 required adb_valve=0");
            end
        end
    end

    initial begin
        logic ra, rg, rad;
        logic [2:0] lv;
        int n, div;
        reset = 1'b0; tick = 1'b0; req_asp = 1'b1; req_got = 1'b0; req_adb = 1'b0; level = 3'd5;
        model_reset();

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1);
        hold(30, 1, 0, 0, 3'd5, 1);                 // sprinkler runs back to back
        hold(4,  0, 0, 0, 3'd5, 1);
        hold(70, 1, 1, 0, 3'd5, 2);                 // round-robin ASP/GOT
        hold(4,  0, 0, 0, 3'd5, 1);
        hold(14, 1, 0, 1, 3'd5, 1);                 // dosed run then flush
        hold(8,  0, 0, 0, 3'd5, 1);
        hold(16, 0, 1, 1, 3'd5, 1);                 // adb ignored for drip
        hold(4,  0, 0, 0, 3'd5, 1);
        hold(4,  1, 0, 1, 3'd5, 1);                 // level drop mid dosed run
        hold(3,  1, 0, 1, 3'd1, 1);
        hold(8,  0, 0, 0, 3'd3, 1);
        hold(6,  0, 1, 0, 3'd5, 1);                 // drip request drop
        hold(3,  0, 0, 0, 3'd5, 1);
        hold(1,  1, 1, 1, 3'd1, 1);                 // fault from idle
        hold(2,  0, 0, 0, 3'd4, 1);
        hold(4,  1, 0, 1, 3'd5, 1);                 // reset during dosed run
        step(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1);
        hold(6,  0, 0, 0, 3'd5, 1);
        hold(2400, 1, 0, 0, 3'd6, 1);               // >256 completed runs

        for (int s = 0; s < 400; s++) begin
            ra  = 1'($urandom_range(0, 1));
            rg  = 1'($urandom_range(0, 1));
            rad = 1'($urandom_range(0, 1));
            lv  = ($urandom_range(0, 15) < 2) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 7));
            n   = int'($urandom_range(1, 20));
            div = int'($urandom_range(1, 3));
            if ($urandom_range(0, 60) == 0) step(1'b0, ra, rg, rad, lv, 1'b1);
            else hold(n, ra, rg, rad, lv, div);
        end

        @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irrigation_scheduler.md
Name: irrigation_scheduler

Overview:
- Sequences the shared tank outlet between the two irrigation requesters, sprinkler (asp) and drip (got).
- Gates each run on tank level and times the run in ticks from the divided system clock.
- After any fertilized (adb) run, inserts a mandatory line-cleaning flush.
- Sits between the user switches and the tank-level, valve and cleaning logic, and replaces ad-hoc OR-ing of asp/got.

Parameters:
- ASP_TICKS, 8, sprinkler run length in ticks (1..2^CNT_W-1)
- GOT_TICKS, 12, drip run length in ticks (1..2^CNT_W-1)
- CLEAN_TICKS, 4, cleaning flush length in ticks (1..2^CNT_W-1)
- MIN_LEVEL, 2, minimum tank level code (0..7) at which the outlet may be opened
- CNT_W, 8, tick-counter width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- tick  in  1  one-clock enable pulse from the clock divisor chain; all durations count ticks
- req_asp  in  1  sprinkler request (level-sensitive)
- req_got  in  1  drip request (level-sensitive)
- req_adb  in  1  fertilizer request; honoured only together with a sprinkler grant
- level  in  3  tank level code (0 = empty, 7 = full)
- grant_asp  out  1  sprinkler run active
- grant_got  out  1  drip run active
- outlet_open  out  1  tank outlet valve open (any run or flush)
- adb_valve  out  1  fertilizer injector open
- cleaning  out  1  cleaning flush in progress
- err_low  out  1  level fault latched
- state_o  out  3  encoded FSM state, for the matrix display

Behaviour:
- All outputs are registered. On reset low, every output is 0, the state is IDLE, the counter is 0, last_served is GOT (so ASP wins the first tie), and dose_pend is 0.
- Tick gating: state changes caused by run or flush expiry occur only on clock edges with tick=1. Request, level and abort decisions are evaluated on every clock edge.
- States and encodings:
  - IDLE=0, RUN_ASP=1, RUN_GOT=2, CLEAN=3, FAULT=4; codes 5-7 are unused and recover to IDLE.
- IDLE:
  - If any request is present and level < MIN_LEVEL, go to FAULT and set err_low=1.
  - Else if exactly one of req_asp/req_got is set, start that run.
  - If both are set, grant the one that is not last_served (round-robin), then update last_served.
  - Starting a run loads the counter with its TICKS-1 value. Starting RUN_ASP also latches dose_pend = req_adb.
- RUN_x:
  - grant_x=1 and outlet_open=1; adb_valve = dose_pend, and only in RUN_ASP.
  - On each tick with counter≠0, decrement the counter.
  - On a tick with counter=0 (run complete), go to CLEAN if dose_pend, else IDLE.
  - If the request drops mid-run, abort on the next clock edge, with the same CLEAN/IDLE rule.
  - If level < MIN_LEVEL mid-run, abort to FAULT and set err_low=1; this takes priority over expiry and request-drop on the same edge.
  - A request from the other source during a run is ignored until the run ends; there is no preemption.
  - Latency: the first grant appears 1 clock after a valid request is seen in IDLE. Run length is exactly TICKS ticks counted from the first tick after the grant.
- CLEAN:
  - cleaning=1, outlet_open=1, all grants 0, adb_valve 0; counter loaded with CLEAN_TICKS-1.
  - On expiry, clear dose_pend and go to IDLE.
  - Requests are ignored. A low level aborts to FAULT; dose_pend is kept.
- FAULT:
  - All valves closed.
  - When level ≥ MIN_LEVEL, go to CLEAN if dose_pend is set, otherwise to IDLE; err_low clears on that same edge.
- Guaranteed: grant_asp and grant_got are never both 1, and adb_valve is never 1 unless grant_asp is 1.
- An asynchronous reset mid-run closes all valves immediately. dose_pend is lost, so no flush follows.

Optional Feature:
- Macro: IRRIG_RUN_COUNT_EN.
- Defined: adds output run_count (8 bits), reset to 0. It increments on each run that completes normally (not aborted), saturates at 255, and flushes do not count.
- Undefined: the port and its counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package irrig_pkg:
  - state enum irrig_state_t (IDLE..FAULT, 3 bits);
  - LEVEL_W=3;
  - the state_o encodings, for reuse by the matrix display mode logic.
- One sub-module, irrig_tick_timer: loadable down-counter with tick enable and a done flag, instantiated once and shared by the run and flush states.

Test Plan:
- Reset low with req_asp=1 and level=5: all outputs 0. After reset is released: grant_asp=1 one clock later, held for exactly 8 ticks, then IDLE.
- req_asp=req_got=1 held at level=5: ASP runs 8 ticks, then GOT runs 12 ticks, then ASP again; no overlap, never both grants high.
- req_asp=1 with req_adb=1: adb_valve=1 throughout RUN_ASP, then CLEAN for 4 ticks (cleaning=1, outlet_open=1), then IDLE. req_adb with only req_got gives adb_valve=0 and no flush.
- Level drops 5→1 at tick 3 of a fertilized ASP run: next edge FAULT, err_low=1, valves closed. Level returns to 3: CLEAN runs 4 ticks, err_low=0, then IDLE.
- req_got drops after 5 of 12 ticks: grant_got falls on the next clock, state goes to IDLE, and no run_count increment occurs with IRRIG_RUN_COUNT_EN defined.
- IRRIG_RUN_COUNT_EN defined, 256 completed runs: run_count saturates at 255.
